// File: rtl/tft_spi_sink.sv
// Oversampling receiver for the 4-wire TFT SPI bus that decodes CASET/PASET/RAMWR and emits pixel strobes.
// Optional sticky protocol-error output is enabled by defining TFT_SPI_SINK_ERR_EN.
module tft_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int COORD_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_clk,
  input  logic               spi_mosi,
  input  logic               spi_dc,
  input  logic               spi_cs,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic [7:0]         cmd,
  output logic [COORD_W-1:0] x_start,
  output logic [COORD_W-1:0] x_end,
  output logic [COORD_W-1:0] y_start,
  output logic [COORD_W-1:0] y_end,
  output logic               pixel_valid,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic [15:0]        pixel_color,
`ifdef TFT_SPI_SINK_ERR_EN
  output logic               err,
`endif
  output logic               in_ramwr
);

  typedef enum logic [1:0] {IDLE, CASET_P, PASET_P, RAMWR_D} state_t;

  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);

  // Synchronisers carry no reset so a level held across reset cannot look like a fresh edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, dc_sync_q, cs_sync_q;
  logic                   sclk_prev_q;
`ifdef TFT_SPI_SINK_ERR_EN
  logic                   cs_prev_q;
`endif

  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
`ifdef TFT_SPI_SINK_ERR_EN
    cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
`endif
  end

  logic       sclk_s, mosi_s, dc_s, cs_s, sclk_rise;
  logic [7:0] shift_d;

  state_t             state_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic [2:0]         param_idx_q;
  logic               phase_q;
  logic [7:0]         hi_q;
  logic [COORD_W-1:0] cur_x_q, cur_y_q;
  logic               byte_valid_q, byte_dc_q, pixel_valid_q, in_ramwr_q;
  logic [7:0]         byte_data_q, cmd_q;
  logic [COORD_W-1:0] x_start_q, x_end_q, y_start_q, y_end_q, pixel_x_q, pixel_y_q;
  logic [15:0]        pixel_color_q;
`ifdef TFT_SPI_SINK_ERR_EN
  logic               err_q;
  logic               cs_rise;
  assign cs_rise = cs_s & ~cs_prev_q;
`endif

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign shift_d   = {shift_q[6:0], mosi_s};

  // Parameter bytes are 16-bit big-endian; narrower coordinates keep the low bits.
  function automatic logic [COORD_W-1:0] put_byte(input logic [COORD_W-1:0] old,
                                                  input logic [7:0] b, input logic hi);
    logic [15:0] w;
    w = 16'(old);
    if (hi) w[15:8] = b;
    else    w[7:0]  = b;
    return COORD_W'(w);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      param_idx_q   <= 3'd0;
      phase_q       <= 1'b0;
      hi_q          <= 8'd0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= 8'd0;
      byte_dc_q     <= 1'b0;
      cmd_q         <= 8'd0;
      x_start_q     <= '0;
      x_end_q       <= '0;
      y_start_q     <= '0;
      y_end_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      pixel_color_q <= 16'd0;
      in_ramwr_q    <= 1'b0;
`ifdef TFT_SPI_SINK_ERR_EN
      err_q         <= 1'b0;
`endif
    end else begin
      byte_valid_q  <= 1'b0;
      pixel_valid_q <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= 3'd0;
        phase_q   <= 1'b0;
`ifdef TFT_SPI_SINK_ERR_EN
        if (cs_rise && bit_cnt_q != 3'd0) err_q <= 1'b1;
`endif
      end else if (sclk_rise) begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
          byte_data_q  <= shift_d;
          byte_dc_q    <= dc_s;
          if (!dc_s) begin
            cmd_q       <= shift_d;
            param_idx_q <= 3'd0;
            phase_q     <= 1'b0;
            in_ramwr_q  <= 1'b0;
`ifdef TFT_SPI_SINK_ERR_EN
            if (phase_q) err_q <= 1'b1;
`endif
            case (shift_d)
              8'h2A:   state_q <= CASET_P;
              8'h2B:   state_q <= PASET_P;
              8'h2C: begin
                state_q    <= RAMWR_D;
                in_ramwr_q <= 1'b1;
                cur_x_q    <= x_start_q;
                cur_y_q    <= y_start_q;
              end
              default: state_q <= IDLE;
            endcase
          end else begin
            case (state_q)
              CASET_P, PASET_P: begin
                if (param_idx_q < 3'd4) begin
                  param_idx_q <= param_idx_q + 3'd1;
                  if (state_q == CASET_P) begin
                    if (!param_idx_q[1]) x_start_q <= put_byte(x_start_q, shift_d, ~param_idx_q[0]);
                    else                 x_end_q   <= put_byte(x_end_q, shift_d, ~param_idx_q[0]);
                  end else begin
                    if (!param_idx_q[1]) y_start_q <= put_byte(y_start_q, shift_d, ~param_idx_q[0]);
                    else                 y_end_q   <= put_byte(y_end_q, shift_d, ~param_idx_q[0]);
                  end
                end
`ifdef TFT_SPI_SINK_ERR_EN
                else err_q <= 1'b1;
`endif
              end
              RAMWR_D: begin
                if (!phase_q) begin
                  hi_q    <= shift_d;
                  phase_q <= 1'b1;
                end else begin
                  phase_q       <= 1'b0;
                  pixel_valid_q <= 1'b1;
                  pixel_x_q     <= cur_x_q;
                  pixel_y_q     <= cur_y_q;
                  pixel_color_q <= {hi_q, shift_d};
                  // Raster order inside the window; the last row wraps so the frame repeats.
                  if (cur_x_q == x_end_q) begin
                    cur_x_q <= x_start_q;
                    cur_y_q <= (cur_y_q == y_end_q) ? y_start_q : cur_y_q + COORD_ONE;
                  end else begin
                    cur_x_q <= cur_x_q + COORD_ONE;
                  end
                end
              end
              default: begin
`ifdef TFT_SPI_SINK_ERR_EN
                err_q <= 1'b1;
`endif
              end
            endcase
          end
        end
      end
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign byte_dc     = byte_dc_q;
  assign cmd         = cmd_q;
  assign x_start     = x_start_q;
  assign x_end       = x_end_q;
  assign y_start     = y_start_q;
  assign y_end       = y_end_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign pixel_color = pixel_color_q;
  assign in_ramwr    = in_ramwr_q;
`ifdef TFT_SPI_SINK_ERR_EN
  assign err         = err_q;
`endif

endmodule

// File: tb/tb_tft_spi_sink.sv
// Directed bench for tft_spi_sink: byte path, window setup, raster, abort, mid-pixel command, reset.
module tb_tft_spi_sink;

  logic clk = 1'b0;
  logic rst, spi_clk, spi_mosi, spi_dc, spi_cs;
  logic byte_valid, byte_dc, pixel_valid, in_ramwr;
  logic [7:0] byte_data, cmd;
  logic [15:0] x_start, x_end, y_start, y_end, pixel_x, pixel_y, pixel_color;
`ifdef TFT_SPI_SINK_ERR_EN
  logic err;
`endif

  always #5 clk = ~clk;

  tft_spi_sink #(.SYNC_STAGES(2), .COORD_W(16)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
    .spi_cs(spi_cs), .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .cmd(cmd), .x_start(x_start), .x_end(x_end), .y_start(y_start), .y_end(y_end),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_color(pixel_color),
`ifdef TFT_SPI_SINK_ERR_EN
    .err(err),
`endif
    .in_ramwr(in_ramwr)
  );

  typedef struct {
    logic [7:0]  b;
    logic        dc;
    logic [7:0]  cmd;
    logic [15:0] xs, xe, ys, ye;
    logic        ramwr;
    logic        pix;
    logic [15:0] px, py, col;
  } vec_t;

  vec_t vq[$];
  int tests = 0;
  int fails = 0;
  int bv_cnt = 0;
  int pv_cnt = 0;
  logic [7:0]  mon_byte;
  logic        mon_dc;
  logic [15:0] mon_px, mon_py, mon_col;

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt   <= bv_cnt + 1;
      mon_byte <= byte_data;
      mon_dc   <= byte_dc;
    end
    if (pixel_valid) begin
      pv_cnt  <= pv_cnt + 1;
      mon_px  <= pixel_x;
      mon_py  <= pixel_y;
      mon_col <= pixel_color;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    spi_clk  = 1'b0;
    tick(2);
    spi_clk  = 1'b1;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    spi_dc = dc;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    tick(4);
  endtask

  task automatic addv(input logic [7:0] b, input logic dc, input logic [7:0] c,
                      input logic [15:0] xs, input logic [15:0] xe,
                      input logic [15:0] ys, input logic [15:0] ye, input logic r,
                      input logic p, input logic [15:0] px, input logic [15:0] py,
                      input logic [15:0] col);
    vec_t v;
    v = '{b: b, dc: dc, cmd: c, xs: xs, xe: xe, ys: ys, ye: ye, ramwr: r,
          pix: p, px: px, py: py, col: col};
    vq.push_back(v);
  endtask

  initial begin
    int b0, p0, lat;
    logic [7:0] v8;

    // Window setup, raster with wrap, mid-pixel command, over-long CASET.
    addv(8'h2A,0, 8'h2A, 0,0,0,0,    0, 0, 0,0,0);
    addv(8'h00,1, 8'h2A, 0,0,0,0,    0, 0, 0,0,0);
    addv(8'h05,1, 8'h2A, 5,0,0,0,    0, 0, 0,0,0);
    addv(8'h00,1, 8'h2A, 5,0,0,0,    0, 0, 0,0,0);
    addv(8'h07,1, 8'h2A, 5,7,0,0,    0, 0, 0,0,0);
    addv(8'h2B,0, 8'h2B, 5,7,0,0,    0, 0, 0,0,0);
    addv(8'h00,1, 8'h2B, 5,7,0,0,    0, 0, 0,0,0);
    addv(8'h0A,1, 8'h2B, 5,7,10,0,   0, 0, 0,0,0);
    addv(8'h00,1, 8'h2B, 5,7,10,0,   0, 0, 0,0,0);
    addv(8'h0B,1, 8'h2B, 5,7,10,11,  0, 0, 0,0,0);
    addv(8'h2C,0, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'hF8,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h00,1, 8'h2C, 5,7,10,11,  1, 1, 5,10,16'hF800);
    addv(8'hF8,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h00,1, 8'h2C, 5,7,10,11,  1, 1, 6,10,16'hF800);
    addv(8'hF8,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h00,1, 8'h2C, 5,7,10,11,  1, 1, 7,10,16'hF800);
    addv(8'hF8,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h00,1, 8'h2C, 5,7,10,11,  1, 1, 5,11,16'hF800);
    addv(8'hF8,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h00,1, 8'h2C, 5,7,10,11,  1, 1, 6,11,16'hF800);
    addv(8'hF8,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h00,1, 8'h2C, 5,7,10,11,  1, 1, 7,11,16'hF800);
    addv(8'hF8,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h00,1, 8'h2C, 5,7,10,11,  1, 1, 5,10,16'hF800);
    addv(8'h12,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h34,1, 8'h2C, 5,7,10,11,  1, 1, 6,10,16'h1234);
    addv(8'h12,1, 8'h2C, 5,7,10,11,  1, 0, 0,0,0);
    addv(8'h2A,0, 8'h2A, 5,7,10,11,  0, 0, 0,0,0);
    addv(8'h00,1, 8'h2A, 5,7,10,11,  0, 0, 0,0,0);
    addv(8'h01,1, 8'h2A, 1,7,10,11,  0, 0, 0,0,0);
    addv(8'h01,1, 8'h2A, 1,16'h0107,10,11, 0, 0, 0,0,0);
    addv(8'h09,1, 8'h2A, 1,16'h0109,10,11, 0, 0, 0,0,0);
    addv(8'h99,1, 8'h2A, 1,16'h0109,10,11, 0, 0, 0,0,0);

    rst = 1'b0; spi_clk = 1'b0; spi_mosi = 1'b0; spi_dc = 1'b0; spi_cs = 1'b0;
    tick(4);
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_in_ramwr", in_ramwr, 0);
`ifdef TFT_SPI_SINK_ERR_EN
    chk("rst_err", err, 0);
`endif
    rst = 1'b1;
    tick(4);

    // Partial byte aborted by cs, then a full command byte.
    spi_dc = 1'b0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    spi_cs = 1'b1;
    tick(4);
    spi_cs = 1'b0;
    tick(4);
    chk("abort_partial_cnt", bv_cnt, 0);
    send_byte(8'h3C, 1'b0);
    chk("abort_cnt", bv_cnt, 1);
    chk("abort_data", mon_byte, 8'h3C);
    chk("abort_cmd", cmd, 8'h3C);
`ifdef TFT_SPI_SINK_ERR_EN
    chk("abort_err", err, 1);
`endif

    // Byte latency from last spi_clk rise.
    b0 = bv_cnt;
    v8 = 8'hA5;
    spi_dc = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(v8[i]);
    spi_mosi = v8[0];
    spi_clk = 1'b0;
    tick(2);
    spi_clk = 1'b1;
    lat = 0;
    do begin
      tick(1);
      lat++;
    end while (!byte_valid && lat < 20);
    chk("latency", lat, 3);
    tick(6);
    chk("a5_cnt", bv_cnt - b0, 1);
    chk("a5_data", mon_byte, 8'hA5);
    chk("a5_dc", mon_dc, 1);

    foreach (vq[i]) begin
      b0 = bv_cnt;
      p0 = pv_cnt;
      send_byte(vq[i].b, vq[i].dc);
      chk($sformatf("v%0d_bytes", i), bv_cnt - b0, 1);
      chk($sformatf("v%0d_bdata", i), mon_byte, vq[i].b);
      chk($sformatf("v%0d_bdc", i), mon_dc, vq[i].dc);
      chk($sformatf("v%0d_pixels", i), pv_cnt - p0, vq[i].pix);
      if (vq[i].pix) begin
        chk($sformatf("v%0d_px", i), mon_px, vq[i].px);
        chk($sformatf("v%0d_py", i), mon_py, vq[i].py);
        chk($sformatf("v%0d_col", i), mon_col, vq[i].col);
      end
      chk($sformatf("v%0d_cmd", i), cmd, vq[i].cmd);
      chk($sformatf("v%0d_win", i), {x_start, x_end}, {vq[i].xs, vq[i].xe});
      chk($sformatf("v%0d_winy", i), {y_start, y_end}, {vq[i].ys, vq[i].ye});
      chk($sformatf("v%0d_ramwr", i), in_ramwr, vq[i].ramwr);
    end

    // Reset in the middle of a pixel while in RAMWR.
    send_byte(8'h2C, 1'b0);
    send_byte(8'hF8, 1'b1);
    chk("pre_rst_ramwr", in_ramwr, 1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    chk("mrst_cmd", cmd, 0);
    chk("mrst_win", {x_start, x_end, y_start, y_end}, 0);
    chk("mrst_ramwr", in_ramwr, 0);
    chk("mrst_byte", {byte_data, byte_dc}, 0);
    chk("mrst_pixel", {pixel_x, pixel_y}, 0);
    chk("mrst_color", pixel_color, 0);
`ifdef TFT_SPI_SINK_ERR_EN
    chk("mrst_err", err, 0);
`endif
    b0 = bv_cnt;
    p0 = pv_cnt;
    send_byte(8'h00, 1'b1);
    chk("post_rst_bytes", bv_cnt - b0, 1);
    chk("post_rst_pixels", pv_cnt - p0, 0);
    chk("post_rst_ramwr", in_ramwr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tft_spi_sink.md
Name: tft_spi_sink

Overview:
- Receive-side counterpart of the TFT SPI transmitter.
- Oversamples the 4-wire display bus (clk/mosi/dc/cs) as driven toward the TFT and analyzer header, and reassembles bytes.
- Decodes the ILI9341-style command subset used by the init and scene blocks: CASET 0x2A, PASET 0x2B, RAMWR 0x2C.
- Emits one pixel strobe per RGB565 pixel with its screen coordinate. Used as an on-chip bus checker and as the decoder in the simulation model of the panel.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on spi_clk/spi_mosi/spi_dc/spi_cs (minimum 2).
- COORD_W, 16, width of column/page coordinates.

Ports:
- clk  in  1  system clock; spi_clk must be at most clk/4.
- rst  in  1  reset, synchronous, active-low.
- spi_clk  in  1  serial clock; data sampled on its rising edge.
- spi_mosi  in  1  serial data, MSB first.
- spi_dc  in  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
- spi_cs  in  1  chip select, active-low; may be tied 0.
- byte_valid  out  1  one-clk pulse per completed byte.
- byte_data  out  8  last completed byte.
- byte_dc  out  1  dc level of last completed byte.
- cmd  out  8  last command byte received.
- x_start, x_end, y_start, y_end  out  COORD_W each  current window.
- pixel_valid  out  1  one-clk pulse per completed pixel.
- pixel_x, pixel_y  out  COORD_W each  coordinate of strobed pixel.
- pixel_color  out  16  RGB565 of strobed pixel, first byte = [15:8].
- in_ramwr  out  1  high while RAMWR data phase is active.

Behaviour:
- Reset (rst=0 at posedge clk) forces all outputs to 0, the command state to IDLE, and bit/byte counters to 0. This applies mid-byte or mid-pixel; partial data is discarded.
- Input path: SYNC_STAGES flops per line, then a rising-edge detect on synced spi_clk. Fixed latency from last spi_clk rising edge to byte_valid is SYNC_STAGES+1 clk.
- Shifter: 3-bit bit counter. On each rising edge with synced cs=0: shift mosi into bit 0 and increment. On count 7: byte_valid=1, byte_data/byte_dc updated, counter wraps to 0.
- spi_cs high: clears bit counter and pixel-byte phase immediately; no byte_valid for the partial byte. Command state is kept, so RAMWR resumes after re-select.
- Command FSM states: IDLE, CASET_P, PASET_P, RAMWR_D.
  - Any byte with dc=0 loads cmd. It selects CASET_P (0x2A), PASET_P (0x2B), or RAMWR_D (0x2C); any other value selects IDLE. The parameter index resets to 0.
  - CASET_P, dc=1 bytes in order: x_start[15:8], x_start[7:0], x_end[15:8], x_end[7:0]. Bytes beyond the 4th are ignored; state stays CASET_P.
  - PASET_P: same layout for y_start/y_end.
  - Window registers update byte-wise as each parameter arrives; upper bits are truncated when COORD_W<16.
  - RAMWR_D: in_ramwr=1. Entry sets cur_x=x_start, cur_y=y_start, pixel-byte phase=0.
    - Phase 0: latch high byte.
    - Phase 1: pixel_valid=1 with pixel_x=cur_x, pixel_y=cur_y, pixel_color={hi,byte}.
    - After each pixel: if cur_x==x_end then cur_x=x_start and cur_y advances; else cur_x+1.
    - cur_y at y_end wraps to y_start, so the frame repeats in-window.
  - dc=1 bytes in IDLE are ignored.
- A dc=0 byte arriving in RAMWR_D with phase=1 drops the pending high byte; no pixel is emitted.
- pixel_valid coincides with the byte_valid of the second pixel byte. Both strobes are registered.
- Start greater than end (x_start>x_end) is legal: cur_x increments with COORD_W wrap until it equals x_end.

Optional Feature:
- Macro TFT_SPI_SINK_ERR_EN.
- When defined, adds output err (1 bit, sticky, cleared only by reset). It is set by any of:
  - a dc=1 byte while IDLE;
  - a 5th+ parameter byte in CASET_P/PASET_P;
  - a cs rising edge with the bit counter nonzero;
  - a command arriving with a pending high pixel byte.
- When undefined, the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Byte path: send 0xA5 with dc=1, cs=0, spi_clk=clk/4 -> single byte_valid, byte_data=0xA5, byte_dc=1, SYNC_STAGES+1 clk after the 8th rising edge.
- Window setup: 0x2A,00,05,00,07 then 0x2B,00,0A,00,0B (params dc=1) -> x_start=5, x_end=7, y_start=10, y_end=11, cmd=0x2B.
- Raster: after window setup, 0x2C then 14 data bytes F8,00 repeated -> 7 pixel_valid with color 0xF800 at (5,10),(6,10),(7,10),(5,11),(6,11),(7,11),(5,10).
- Abort: 5 bits then cs high, then full byte 0x3C -> exactly one byte_valid, data 0x3C; with ERR_EN, err=1.
- Mid-pixel command: in RAMWR send 0x12 (dc=1) then 0x2A (dc=0) -> no pixel_valid, cmd=0x2A, in_ramwr=0.
- Reset mid-frame: rst=0 one clk during RAMWR -> all outputs 0, next dc=1 byte produces no pixel.
